// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// serves both ID read ports and counts retired instructions. Define WB_BYPASS_EN for write-through reads.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [ADDR_W-1:0] wb_rd_addr,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  retire_count
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  retire_q, retire_d;

    assign wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    // Address 0 is excluded here so r0 can never be written, and forwarding never matches it.
    assign wb_we   = wb_valid & wb_reg_write & (wb_rd_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_we) begin
            regs_q[wb_rd_addr] <= wb_data;
        end
    end

    assign retire_d = retire_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst)
            retire_q <= '0;
        else if (wb_valid)
            retire_q <= retire_d;
    end

    assign retire_count = retire_q;

    always_comb begin
        rs_data = (rs_addr == '0) ? '0 : regs_q[rs_addr];
        rt_data = (rt_addr == '0) ? '0 : regs_q[rt_addr];
`ifdef WB_BYPASS_EN
        // wb_we already implies a nonzero destination, so r0 stays zero under bypass.
        if (wb_we && (rs_addr == wb_rd_addr)) rs_data = wb_data;
        if (wb_we && (rt_addr == wb_rd_addr)) rt_data = wb_data;
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a narrow retire counter keeps the wrap test short.
module tb_wb_regfile;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [ADDR_W-1:0] wb_rd_addr, rs_addr, rt_addr;
    logic [DATA_W-1:0] wb_alu_result, wb_mem_data;
    logic [DATA_W-1:0] rs_data, rt_data, wb_data;
    logic              wb_we;
    logic [CNT_W-1:0]  retire_count;

    int tests = 0;
    int fails = 0;
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd_addr(wb_rd_addr), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_data(wb_data), .wb_we(wb_we), .retire_count(retire_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [ADDR_W-1:0] rd,
                         input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
        wb_valid = v; wb_reg_write = rw; wb_mem_to_reg = m2r;
        wb_rd_addr = rd; wb_alu_result = alu; wb_mem_data = mem;
        #1;
    endtask

    task automatic test_reset();
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 1'b1, 1'b0, ADDR_W'(r), 32'hFFFF_FFFF, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rs_addr = 5'd31; rt_addr = 5'd1; #1;
        tests++;
        if (rs_data !== 32'hFFFF_FFFF || rt_data !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL fill: rs31=%h rt1=%h required ffffffff", rs_data, rt_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        for (int r = 0; r < 32; r++) begin
            rs_addr = ADDR_W'(r); rt_addr = ADDR_W'(31 - r); #1;
            tests++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
                fails++;
                $display("FAIL reset_read r%0d: rs=%h rt=%h required 0", r, rs_data, rt_data);
            end
        end
        tests++;
        if (retire_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d required 0", retire_count);
        end
        exp_cnt = '0;
    endtask

    task automatic test_alu_wb();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        tests++;
        if (wb_data !== 32'h1234_5678 || wb_we !== 1'b1) begin
            fails++;
            $display("FAIL alu_sel: wb_data=%h we=%b required 12345678/1", wb_data, wb_we);
        end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rs_addr = 5'd5; #1;
        tests++;
        if (rs_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL alu_commit: rs=%h required 12345678", rs_data);
        end
        tests++;
        if (retire_count !== exp_cnt) begin
            fails++;
            $display("FAIL alu_count: got %0d required %0d", retire_count, exp_cnt);
        end
    endtask

    task automatic test_load_r0();
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_0042, 32'hCAFE_0001);
        tests++;
        if (wb_data !== 32'hCAFE_0001) begin
            fails++;
            $display("FAIL load_sel: wb_data=%h required cafe0001", wb_data);
        end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0055, 32'h0000_0055);
        tests++;
        if (wb_we !== 1'b0) begin
            fails++;
            $display("FAIL r0_we: got %b required 0", wb_we);
        end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        rs_addr = 5'd7; rt_addr = 5'd0; #1;
        tests++;
        if (rs_data !== 32'hCAFE_0001) begin
            fails++;
            $display("FAIL load_commit: rs=%h required cafe0001", rs_data);
        end
        tests++;
        if (rt_data !== 32'h0) begin
            fails++;
            $display("FAIL r0_read: rt=%h required 0", rt_data);
        end
        tests++;
        if (retire_count !== exp_cnt) begin
            fails++;
            $display("FAIL r0_count: got %0d required %0d", retire_count, exp_cnt);
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 1'b1, 1'b0, 5'd3, 32'd9, 32'd9);
        tests++;
        if (wb_we !== 1'b0) begin
            fails++;
            $display("FAIL bubble_we: got %b required 0", wb_we);
        end
        tick();
        rs_addr = 5'd3; #1;
        tests++;
        if (rs_data !== 32'h0 || retire_count !== exp_cnt) begin
            fails++;
            $display("FAIL bubble: r3=%h cnt=%0d required 0/%0d", rs_data, retire_count, exp_cnt);
        end
        drive(1'b1, 1'b0, 1'b0, 5'd3, 32'd9, 32'd9);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tests++;
        if (rs_data !== 32'h0 || retire_count !== exp_cnt) begin
            fails++;
            $display("FAIL nowrite: r3=%h cnt=%0d required 0/%0d", rs_data, retire_count, exp_cnt);
        end
    endtask

    task automatic test_same_cycle();
        logic [DATA_W-1:0] exp_now;
`ifdef WB_BYPASS_EN
        exp_now = 32'h22;
`else
        exp_now = 32'h11;
`endif
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h11, 32'h0);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        rs_addr = 5'd9; rt_addr = 5'd9;
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h22, 32'h0);
        tests++;
        if (rs_data !== exp_now || rt_data !== exp_now) begin
            fails++;
            $display("FAIL hazard_same: rs=%h rt=%h required %h", rs_data, rt_data, exp_now);
        end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tests++;
        if (rs_data !== 32'h22 || rt_data !== 32'h22) begin
            fails++;
            $display("FAIL hazard_next: rs=%h rt=%h required 22", rs_data, rt_data);
        end
    endtask

    task automatic test_wrap_and_reset();
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        while (exp_cnt != 4'hF) begin
            tick();
            exp_cnt = exp_cnt + 1'b1;
        end
        tests++;
        if (retire_count !== 4'hF) begin
            fails++;
            $display("FAIL cnt_max: got %0d required 15", retire_count);
        end
        tick();
        tests++;
        if (retire_count !== 4'h0) begin
            fails++;
            $display("FAIL cnt_wrap: got %0d required 0", retire_count);
        end
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h44, 32'h0);
        tick();
        rs_addr = 5'd4; #1;
        tests++;
        if (rs_data !== 32'h44) begin
            fails++;
            $display("FAIL pre_rst_write: r4=%h required 44", rs_data);
        end
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h77, 32'h0);
        tick();
        tick();
        tests++;
        if (rs_data !== 32'h0 || retire_count !== 4'h0) begin
            fails++;
            $display("FAIL rst_collide: r4=%h cnt=%0d required 0/0", rs_data, retire_count);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        rst = 1'b1;
        rs_addr = '0; rt_addr = '0;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        rst = 1'b0;
        test_reset();
        test_alu_wb();
        test_load_r0();
        test_bubble();
        test_same_cycle();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register in the five-stage CPU.
- Selects writeback data (ALU result or load data), commits it to the architectural register file, and serves the two ID-stage read ports.
- Drives the WB forwarding value to the EX-stage forwarding mux and keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register address width; register count = 2**ADDR_W
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset
- wb_valid  input  1  MEM/WB slot holds a real (non-bubble) instruction
- wb_reg_write  input  1  instruction writes a destination register
- wb_mem_to_reg  input  1  1 = write load data, 0 = write ALU result
- wb_rd_addr  input  ADDR_W  destination register
- wb_alu_result  input  DATA_W  ALU result from MEM/WB
- wb_mem_data  input  DATA_W  load data from MEM/WB
- rs_addr  input  ADDR_W  ID read port A address
- rt_addr  input  ADDR_W  ID read port B address
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_data  output  DATA_W  selected writeback value, to EX forwarding mux
- wb_we  output  1  qualified write enable, to hazard/forwarding unit
- retire_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. On a rst edge, all 2**ADDR_W registers become 0 and retire_count becomes 0.
- While rst is high, commits and counting are suppressed, regardless of other inputs.
- wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result. This path is combinational, with no register stage.
- wb_we = wb_valid & wb_reg_write & (wb_rd_addr != 0). It is combinational.
- Commit: on posedge clk with !rst and wb_we, reg[wb_rd_addr] <= wb_data. Write latency is 1 edge.
- Register 0 is hardwired to 0:
  - Writes to address 0 are dropped.
  - Reads of address 0 always return 0, including under bypass.
- Read ports are combinational from the array (asynchronous read). rs and rt are independent; both may address the same register.
- Retire counter: on posedge clk with !rst and wb_valid, retire_count <= retire_count + 1.
  - Counts bubbles-excluded instructions, including those with wb_reg_write = 0 (stores, branches).
  - Wraps from 2**CNT_W-1 to 0 silently.
- Bubble: wb_valid = 0 means no write and no count, whatever the other fields hold.
- Reset mid-operation: a write presented in the same cycle as rst is lost, and the register reads 0 after the edge.
- Same-cycle write and read of the same nonzero register: see the optional feature.
- No state machine beyond the array and counter. All state updates occur on posedge clk only.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: internal write-through.
  - If wb_we and rs_addr == wb_rd_addr (nonzero), rs_data = wb_data in the same cycle. rt behaves the same way.
  - The hazard unit then needs no WB-to-ID stall.
- Undefined: reads return the pre-commit array value. The new value is visible from the cycle after the commit edge, and the hazard unit must stall ID one cycle on a WB/ID match.

Test Plan:
- Reset: fill regs 1..31 with 0xFFFF_FFFF, assert rst 1 cycle -> every rs/rt read returns 0, and retire_count = 0.
- ALU writeback: wb_valid=1, reg_write=1, mem_to_reg=0, rd=5, alu=0x1234_5678, mem=0xDEAD_BEEF; next cycle rs_addr=5 -> rs_data=0x1234_5678, and retire_count increments by 1.
- Load writeback and r0: rd=7 with mem_to_reg=1 and mem=0xCAFE_0001 -> reg7=0xCAFE_0001. Then rd=0 with data 0x55 -> rt_addr=0 reads 0, wb_we=0, and retire_count still increments.
- Bubble and no-write: wb_valid=0 with reg_write=1, rd=3, alu=9 -> reg3 unchanged and count unchanged. Then wb_valid=1 with reg_write=0 -> reg3 unchanged and count +1.
- Same-cycle hazard: reg9=0x11, write rd=9 alu=0x22 while rs_addr=rt_addr=9 -> with WB_BYPASS_EN both ports read 0x22 in that cycle; without it they read 0x11 in that cycle and 0x22 the next.
- Counter wrap and reset collision: preload retire_count to 2**CNT_W-1, retire one instruction -> 0. Then assert rst together with a write rd=4 alu=0x77 -> reg4=0 after the edge.
